// File: rtl/timer_ctrl_pkg.sv
// Shared state encodings and default timing constants for the timer UI controller.
package timer_ctrl_pkg;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_STOP    = 3'd0,
        ST_RUN     = 3'd1,
        ST_ADJ_SEC = 3'd2,
        ST_ADJ_MIN = 3'd3,
        ST_ADJ_HR  = 3'd4
    } state_t;

    localparam logic [31:0] DEF_CLOCK_FREQ      = 32'd50_000_000;
    localparam logic [19:0] DEF_DEBOUNCE_CYCLES = 20'd500_000;
    localparam logic [31:0] DEF_TIMEOUT_CYCLES  = 32'd500_000_000;
    localparam logic [31:0] DEF_REPEAT_DELAY    = 32'd25_000_000;
    localparam logic [31:0] DEF_REPEAT_PERIOD   = 32'd5_000_000;

    function automatic logic is_adj(input state_t s);
        return (s == ST_ADJ_SEC) || (s == ST_ADJ_MIN) || (s == ST_ADJ_HR);
    endfunction
endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-FF sync -> debounced level -> one-cycle registered press pulse.
// Latency raw edge to o_press: 2 + DEBOUNCE_CYCLES + 1 cycles; no backpressure.
module btn_conditioner
    import timer_ctrl_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_level_d;
    logic        r_press;
    logic [19:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            // Counts consecutive samples that disagree with the current level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;
endmodule

// File: rtl/timer_mode_ctrl.sv
// Button/switch front end and five-state mode FSM driving the timer controls; pulses one cycle after the press event.
// Build macro TIMER_AUTO_REPEAT_EN adds hold-to-repeat increment pulses; no backpressure.
module timer_mode_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter logic [31:0] CLOCK_FREQ      = DEF_CLOCK_FREQ,
    parameter logic [19:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [31:0] TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter logic [31:0] REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_btn_mode,
    input  logic               i_btn_inc,
    input  logic               i_btn_save,
    input  logic               i_sw_run,
    output logic               o_start_stop,
    output logic               o_select_seconds,
    output logic               o_select_minutes,
    output logic               o_select_hours,
    output logic               o_increment,
    output logic               o_save,
    output logic [STATE_W-1:0] o_mode
);
    logic        w_mode_lvl, w_mode_press;
    logic        w_inc_lvl,  w_inc_press;
    logic        w_save_lvl, w_save_press;
    logic        r_run_s1, r_run_s2;
    state_t      r_state, w_next;
    logic        w_is_adj, w_state_chg, w_any_evt, w_timeout;
    logic        w_do_inc, w_do_save, w_rep_evt;
    logic [31:0] r_to_cnt;
    logic        r_increment, r_save;
    logic        w_unused;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_btn_mode), .o_level(w_mode_lvl), .o_press(w_mode_press));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_btn_inc), .o_level(w_inc_lvl), .o_press(w_inc_press));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_save (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_btn_save), .o_level(w_save_lvl), .o_press(w_save_press));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run_s1 <= 1'b0;
            r_run_s2 <= 1'b0;
        end else begin
            r_run_s1 <= i_sw_run;
            r_run_s2 <= r_run_s1;
        end
    end

    assign w_is_adj    = is_adj(r_state);
    assign w_state_chg = (w_next != r_state);
    assign w_any_evt   = w_mode_press | w_inc_press | w_save_press | w_rep_evt;
    assign w_timeout   = w_is_adj & ~w_any_evt & (r_to_cnt == TIMEOUT_CYCLES - 32'd1);
    // Priority mode > save > inc: a lower event sharing a cycle is dropped.
    assign w_do_save   = w_is_adj & w_save_press & ~w_mode_press;
    assign w_do_inc    = w_is_adj & (w_inc_press | w_rep_evt) & ~w_mode_press & ~w_save_press;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_STOP;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_STOP:    if (w_mode_press) w_next = ST_ADJ_SEC;
                        else if (r_run_s2) w_next = ST_RUN;
            ST_RUN:     if (w_mode_press) w_next = ST_ADJ_SEC;
                        else if (!r_run_s2) w_next = ST_STOP;
            ST_ADJ_SEC: if (w_mode_press) w_next = ST_ADJ_MIN;
                        else if (w_timeout) w_next = ST_STOP;
            ST_ADJ_MIN: if (w_mode_press) w_next = ST_ADJ_HR;
                        else if (w_timeout) w_next = ST_STOP;
            ST_ADJ_HR:  if (w_mode_press || w_timeout) w_next = ST_STOP;
            default:    w_next = ST_STOP;
        endcase
    end

    always_comb begin
        o_start_stop     = (r_state == ST_RUN);
        o_select_seconds = (r_state == ST_ADJ_SEC);
        o_select_minutes = (r_state == ST_ADJ_MIN);
        o_select_hours   = (r_state == ST_ADJ_HR);
        o_mode           = r_state;
        o_increment      = r_increment;
        o_save           = r_save;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_increment <= 1'b0;
            r_save      <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_increment <= w_do_inc;
            r_save      <= w_do_save;
            if (!w_is_adj || w_state_chg || w_any_evt) r_to_cnt <= '0;
            else                                       r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

`ifdef TIMER_AUTO_REPEAT_EN
    logic [31:0] r_rep_cnt;
    logic        r_rep_act;
    logic        r_rep_first;

    // First repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD apart.
    assign w_rep_evt = r_rep_act & (r_rep_cnt == (r_rep_first ? REPEAT_DELAY : REPEAT_PERIOD));

    always_ff @(posedge i_clk) begin
        if (i_rst || !w_is_adj || !w_inc_lvl || w_state_chg) begin
            r_rep_act   <= 1'b0;
            r_rep_first <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (w_do_inc || w_rep_evt) begin
            r_rep_act   <= 1'b1;
            r_rep_first <= ~w_rep_evt;
            r_rep_cnt   <= 32'd1;
        end else if (r_rep_act) begin
            r_rep_cnt   <= r_rep_cnt + 32'd1;
        end
    end

    assign w_unused = ^{CLOCK_FREQ, w_mode_lvl, w_save_lvl};
`else
    assign w_rep_evt = 1'b0;
    assign w_unused  = ^{CLOCK_FREQ, REPEAT_DELAY, REPEAT_PERIOD, w_mode_lvl, w_inc_lvl, w_save_lvl};
`endif
endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Randomised and directed bench for timer_mode_ctrl with small timing parameters.
`timescale 1ns/1ps
module tb_timer_mode_ctrl;
    localparam int D    = 4;
    localparam int TMO  = 100;
    localparam int RDLY = 20;
    localparam int RPER = 5;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_inc, btn_save, sw_run;
    logic       start_stop, sel_s, sel_m, sel_h, inc, save;
    logic [2:0] mode;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int inc_cnt = 0, save_cnt = 0, sel_overlap = 0, pulse_back = 0;
    int inc_q[$];
    logic [2:0] save_sel_last = 3'b000;
    logic inc_prev = 1'b0, save_prev = 1'b0;

    timer_mode_ctrl #(
        .CLOCK_FREQ(32'd50_000_000), .DEBOUNCE_CYCLES(20'd4), .TIMEOUT_CYCLES(32'd100),
        .REPEAT_DELAY(32'd20), .REPEAT_PERIOD(32'd5)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn_mode(btn_mode), .i_btn_inc(btn_inc),
        .i_btn_save(btn_save), .i_sw_run(sw_run), .o_start_stop(start_stop),
        .o_select_seconds(sel_s), .o_select_minutes(sel_m), .o_select_hours(sel_h),
        .o_increment(inc), .o_save(save), .o_mode(mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (inc) begin inc_cnt++; inc_q.push_back(cyc); end
        if (save) begin save_cnt++; save_sel_last = {sel_h, sel_m, sel_s}; end
        if ($countones({sel_s, sel_m, sel_h}) > 1) sel_overlap++;
        if ((inc && inc_prev) || (save && save_prev)) pulse_back++;
        inc_prev  = inc;
        save_prev = save;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; sw_run = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_save = 1'b0;
        tick(3);
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        checks++; if (start_stop !== 1'b0) begin errors++; $display("FAIL reset_start_stop: got %b expected 0", start_stop); end
        checks++; if ({sel_s, sel_m, sel_h} !== 3'b000) begin errors++; $display("FAIL reset_selects: got %b expected 000", {sel_s, sel_m, sel_h}); end
        checks++; if ({inc, save} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {inc, save}); end
        rst = 1'b0;
        tick(2);
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL run_sync_delay: got %0d expected 0", mode); end
        tick(1);
        checks++; if (mode !== 3'd1) begin errors++; $display("FAIL run_enter: got %0d expected 1", mode); end
        checks++; if (start_stop !== 1'b1) begin errors++; $display("FAIL run_start_stop: got %b expected 1", start_stop); end
    endtask

    task automatic test_glitch_and_latency;
        btn_mode = 1'b1; tick(3); btn_mode = 1'b0; tick(10);
        checks++; if (mode !== 3'd1) begin errors++; $display("FAIL glitch_reject: got %0d expected 1", mode); end
        btn_mode = 1'b1;
        tick(2 + D + 1);
        checks++; if (mode !== 3'd1) begin errors++; $display("FAIL mode_early: got %0d expected 1", mode); end
        tick(1);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL mode_latency: got %0d expected 2", mode); end
        checks++; if ({sel_s, start_stop} !== 2'b10) begin errors++; $display("FAIL adj_sec_outputs: got %b expected 10", {sel_s, start_stop}); end
        btn_mode = 1'b0; tick(8);
    endtask

    task automatic test_mode_save_collision;
        int s0 = save_cnt;
        btn_mode = 1'b1; btn_save = 1'b1;
        tick(8);
        checks++; if (mode !== 3'd3) begin errors++; $display("FAIL collide_mode: got %0d expected 3", mode); end
        btn_mode = 1'b0; btn_save = 1'b0; tick(8);
        checks++; if (save_cnt - s0 !== 0) begin errors++; $display("FAIL collide_no_save: got %0d expected 0", save_cnt - s0); end
    endtask

    task automatic test_inc_save;
        int i0 = inc_cnt, s0 = save_cnt, qi = inc_q.size(), t_start = cyc;
        for (int k = 0; k < 3; k++) begin
            btn_inc = 1'b1; tick(6); btn_inc = 1'b0; tick(8);
        end
        btn_save = 1'b1; tick(6); btn_save = 1'b0; tick(8);
        checks++;
        if (inc_q.size() <= qi) begin errors++; $display("FAIL inc_latency: got no pulse expected offset 8"); end
        else if (inc_q[qi] - t_start !== 2 + D + 2) begin errors++; $display("FAIL inc_latency: got %0d expected %0d", inc_q[qi] - t_start, 2 + D + 2); end
        checks++; if (inc_cnt - i0 !== 3) begin errors++; $display("FAIL inc_count: got %0d expected 3", inc_cnt - i0); end
        checks++; if (save_cnt - s0 !== 1) begin errors++; $display("FAIL save_count: got %0d expected 1", save_cnt - s0); end
        checks++; if (save_sel_last !== 3'b010) begin errors++; $display("FAIL save_with_select: got %b expected 010", save_sel_last); end
        checks++; if (mode !== 3'd3) begin errors++; $display("FAIL save_keeps_state: got %0d expected 3", mode); end
    endtask

    task automatic test_random;
        int i0 = inc_cnt, s0 = save_cnt, exp_inc = 0, exp_save = 0;
        bit prev_glitch = 1'b0;
        for (int k = 0; k < 14; k++) begin
            int which = $urandom_range(0, 1);
            int h = prev_glitch ? $urandom_range(D, 10) : $urandom_range(1, 10);
            int g = $urandom_range(D + 2, 10);
            if (which == 1) btn_save = 1'b1; else btn_inc = 1'b1;
            tick(h);
            btn_save = 1'b0; btn_inc = 1'b0;
            tick(g);
            // A press registers only when the raw level holds for D samples.
            if (h >= D) begin
                if (which == 1) exp_save++; else exp_inc++;
            end
            prev_glitch = (h < D);
        end
        tick(4);
        checks++; if (inc_cnt - i0 !== exp_inc) begin errors++; $display("FAIL rand_inc: got %0d expected %0d", inc_cnt - i0, exp_inc); end
        checks++; if (save_cnt - s0 !== exp_save) begin errors++; $display("FAIL rand_save: got %0d expected %0d", save_cnt - s0, exp_save); end
        checks++; if (mode !== 3'd3) begin errors++; $display("FAIL rand_state: got %0d expected 3", mode); end
    endtask

    task automatic test_timeout;
        int s0 = save_cnt;
        sw_run = 1'b0;
        btn_mode = 1'b1; tick(6); btn_mode = 1'b0; tick(2);
        checks++; if (mode !== 3'd4) begin errors++; $display("FAIL enter_adj_hr: got %0d expected 4", mode); end
        tick(TMO - 1);
        checks++; if (mode !== 3'd4) begin errors++; $display("FAIL timeout_early: got %0d expected 4", mode); end
        tick(1);
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL timeout_exit: got %0d expected 0", mode); end
        checks++; if (save_cnt - s0 !== 0) begin errors++; $display("FAIL timeout_no_save: got %0d expected 0", save_cnt - s0); end
        checks++; if (sel_h !== 1'b0) begin errors++; $display("FAIL timeout_sel_h: got %b expected 0", sel_h); end
    endtask

    task automatic test_reset_mid;
        btn_mode = 1'b1; tick(8);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL mid_enter_adj: got %0d expected 2", mode); end
        btn_mode = 1'b0; btn_inc = 1'b1; tick(3);
        rst = 1'b1; tick(1);
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL mid_reset_mode: got %0d expected 0", mode); end
        checks++;
        if ({start_stop, sel_s, sel_m, sel_h, inc, save} !== 6'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got %b expected 000000", {start_stop, sel_s, sel_m, sel_h, inc, save});
        end
        rst = 1'b0; btn_inc = 1'b0; tick(10);
    endtask

    task automatic test_auto_repeat;
        int exp_off[$];
        int qi, t0, n;
        btn_mode = 1'b1; tick(8); btn_mode = 1'b0; tick(8);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL rep_enter_adj: got %0d expected 2", mode); end
        qi = inc_q.size();
        btn_inc = 1'b1;
        n = 0;
        while (inc !== 1'b1 && n < 20) begin tick(1); n++; end
        checks++;
        if (inc !== 1'b1) begin
            errors++; $display("FAIL rep_first_pulse: got none within 20 cycles expected a pulse");
            btn_inc = 1'b0; tick(10);
        end else begin
            t0 = cyc;
            tick(56);
            btn_inc = 1'b0;
            tick(30);
            exp_off.push_back(0);
`ifdef TIMER_AUTO_REPEAT_EN
            for (int o = RDLY; o <= 60; o += RPER) exp_off.push_back(o);
`endif
            checks++;
            if (inc_q.size() - qi !== exp_off.size()) begin
                errors++; $display("FAIL rep_count: got %0d expected %0d", inc_q.size() - qi, exp_off.size());
            end
            for (int k = 0; k < exp_off.size() && qi + k < inc_q.size(); k++) begin
                checks++;
                if (inc_q[qi + k] - t0 !== exp_off[k]) begin
                    errors++; $display("FAIL rep_offset_%0d: got %0d expected %0d", k, inc_q[qi + k] - t0, exp_off[k]);
                end
            end
        end
    endtask

    task automatic test_invariants;
        checks++; if (sel_overlap !== 0) begin errors++; $display("FAIL select_overlap: got %0d cycles expected 0", sel_overlap); end
        checks++; if (pulse_back !== 0) begin errors++; $display("FAIL pulse_back_to_back: got %0d cycles expected 0", pulse_back); end
    endtask

    initial begin
        test_reset();
        test_glitch_and_latency();
        test_mode_save_collision();
        test_inc_save();
        test_random();
        test_timeout();
        test_reset_mid();
        test_auto_repeat();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
